// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_stage (with imhotep_pkg)
// Description : RV32I decode/issue stage. Drives the register-file read
//               addresses, decodes the ALU operation, selects the operands and
//               holds the result in a single-entry ID/EX register with a
//               valid/ready handshake, stall and flush.
// Revision    : 1.0 - initial release
// ============================================================================

package imhotep_pkg;
  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_JMPR = 4'd7
  } op_alu_e;
endpackage

module id_stage
  import imhotep_pkg::*;
#(
  parameter int unsigned XLEN       = imhotep_pkg::XLEN,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           instr_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [REG_ADDR_W-1:0] rs1_addr_o,
  output logic [REG_ADDR_W-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [XLEN-1:0]       in1_o,
  output logic [XLEN-1:0]       in2_o,
  output logic [XLEN-1:0]       pc_o,
  output op_alu_e               op_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  rd_we_o,
  output logic                  illegal_o
);

  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;

  // Instruction fields
  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic [REG_ADDR_W-1:0] w_rd;

  assign w_opc = instr_i[6:0];
  assign w_f3  = instr_i[14:12];
  assign w_f7  = instr_i[31:25];
  assign w_rd  = instr_i[11:7];

  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  // Sign-extended immediates (bit 31 is always the immediate sign)
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;

  assign w_imm_i = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign w_imm_s = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign w_imm_u = {{(XLEN-31){instr_i[31]}}, instr_i[30:12], 12'h000};
  assign w_imm_j = {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};

  // Decoded bundle
  op_alu_e         w_op;
  logic [XLEN-1:0] w_in1;
  logic [XLEN-1:0] w_in2;
  logic            w_we;
  logic            w_ill;

  // Decode opcode/funct fields into ALU op, operands and writeback enable
  always_comb begin
    w_op  = ALU_NOP;
    w_in1 = '0;
    w_in2 = '0;
    w_we  = 1'b0;
    w_ill = 1'b1;
    case (w_opc)
      c_opc_op: begin
        w_ill = 1'b0;
        w_we  = 1'b1;
        w_in1 = rs1_data_i;
        w_in2 = rs2_data_i;
        case ({w_f7, w_f3})
          {7'h00, 3'b000}: w_op = ALU_ADD;
          {7'h20, 3'b000}: w_op = ALU_SUB;
          {7'h00, 3'b111}: w_op = ALU_AND;
          {7'h00, 3'b110}: w_op = ALU_OR;
          {7'h00, 3'b100}: w_op = ALU_XOR;
          {7'h00, 3'b010}: w_op = ALU_SLT;
          default:         w_ill = 1'b1;
        endcase
      end
      c_opc_op_imm: begin
        w_ill = 1'b0;
        w_we  = 1'b1;
        w_in1 = rs1_data_i;
        w_in2 = w_imm_i;
        case (w_f3)
          3'b000:  w_op = ALU_ADD;
          3'b111:  w_op = ALU_AND;
          3'b110:  w_op = ALU_OR;
          3'b100:  w_op = ALU_XOR;
          3'b010:  w_op = ALU_SLT;
          default: w_ill = 1'b1;
        endcase
      end
      c_opc_lui: begin
        w_ill = 1'b0;
        w_we  = 1'b1;
        w_op  = ALU_ADD;
        w_in2 = w_imm_u;
      end
      c_opc_auipc: begin
        w_ill = 1'b0;
        w_we  = 1'b1;
        w_op  = ALU_ADD;
        w_in1 = pc_i;
        w_in2 = w_imm_u;
      end
      c_opc_jal: begin
        w_ill = 1'b0;
        w_we  = 1'b1;
        w_op  = ALU_ADD;
        w_in1 = pc_i;
        w_in2 = w_imm_j;
      end
      c_opc_jalr: begin
        w_ill = (w_f3 != 3'b000);
        w_we  = 1'b1;
        w_op  = ALU_JMPR;
        w_in1 = rs1_data_i;
        w_in2 = w_imm_i;
      end
      c_opc_load: begin
        w_ill = !(w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        w_we  = 1'b1;
        w_op  = ALU_ADD;
        w_in1 = rs1_data_i;
        w_in2 = w_imm_i;
      end
      c_opc_store: begin
        w_ill = !(w_f3 inside {3'b000, 3'b001, 3'b010});
        w_op  = ALU_ADD;
        w_in1 = rs1_data_i;
        w_in2 = w_imm_s;
      end
      c_opc_branch: begin
        w_ill = !(w_f3 inside {3'b000, 3'b001});
        w_op  = ALU_SUB;
        w_in1 = rs1_data_i;
        w_in2 = rs2_data_i;
      end
      default: w_ill = 1'b1;
    endcase

    // Unsupported encodings issue as an inert bubble flagged illegal
    if (w_ill) begin
      w_op  = ALU_NOP;
      w_in1 = '0;
      w_in2 = '0;
      w_we  = 1'b0;
    end

    // Writes to x0 are architecturally discarded
    if (w_rd == '0) begin
      w_we = 1'b0;
    end
  end

  // ID/EX register
  logic                  r_valid;
  logic [XLEN-1:0]       r_in1;
  logic [XLEN-1:0]       r_in2;
  logic [XLEN-1:0]       r_pc;
  op_alu_e               r_op;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_we;
  logic                  r_ill;
  logic                  w_load;

  assign ready_o = !r_valid || ready_i;
  assign w_load  = valid_i && ready_o;

  // Pipeline register: flush beats load, load beats drain, otherwise hold
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_pc    <= '0;
      r_op    <= ALU_NOP;
      r_rd    <= '0;
      r_we    <= 1'b0;
      r_ill   <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_in1   <= w_in1;
      r_in2   <= w_in2;
      r_pc    <= pc_i;
      r_op    <= w_op;
      r_rd    <= w_rd;
      r_we    <= w_we;
      r_ill   <= w_ill;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o   = r_valid;
  assign in1_o     = r_in1;
  assign in2_o     = r_in2;
  assign pc_o      = r_pc;
  assign op_o      = r_op;
  assign rd_addr_o = r_rd;
  assign rd_we_o   = r_we;
  assign illegal_o = r_ill;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage
// Description : Self-checking bench for id_stage: directed decode vectors,
//               stall/flush/reset sequences and randomized traffic checked
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_id_stage;
  import imhotep_pkg::*;

  typedef struct {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] pc;
    op_alu_e     op;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } bnd_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    bnd_t        exp;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] in1_o;
  logic [31:0] in2_o;
  logic [31:0] pc_o;
  op_alu_e     op_o;
  logic [4:0]  rd_addr_o;
  logic        rd_we_o;
  logic        illegal_o;

  id_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_i(instr_i), .pc_i(pc_i),
    .valid_i(valid_i), .ready_o(ready_o), .rs1_addr_o(rs1_addr_o),
    .rs2_addr_o(rs2_addr_o), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .in1_o(in1_o),
    .in2_o(in2_o), .pc_o(pc_o), .op_o(op_o), .rd_addr_o(rd_addr_o),
    .rd_we_o(rd_we_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  int   checks = 0;
  int   errors = 0;
  bit   m_valid;
  bnd_t m_b;
  bnd_t reset_b;
  vec_t vecs[15];

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bundle(input bnd_t e);
    check("in1_o", in1_o, e.in1);
    check("in2_o", in2_o, e.in2);
    check("pc_o", pc_o, e.pc);
    check("op_o", 32'(op_o), 32'(e.op));
    check("rd_addr_o", 32'(rd_addr_o), 32'(e.rd));
    check("rd_we_o", 32'(rd_we_o), 32'(e.we));
    check("illegal_o", 32'(illegal_o), 32'(e.ill));
  endtask

  // One clock of traffic; model follows the handshake rules at transaction level
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic fl, input logic rdy, input bnd_t dec);
    bit accept;
    valid_i = v; instr_i = ins; pc_i = pc; rs1_data_i = d1; rs2_data_i = d2;
    flush_i = fl; ready_i = rdy;
    #1;
    accept = !m_valid || rdy;
    check("ready_o", 32'(ready_o), 32'(accept));
    check("rs1_addr_o", 32'(rs1_addr_o), 32'(ins[19:15]));
    check("rs2_addr_o", 32'(rs2_addr_o), 32'(ins[24:20]));
    if (fl) m_valid = 1'b0;
    else if (v && accept) begin
      m_valid = 1'b1;
      m_b     = dec;
      m_b.pc  = pc;
    end else if (rdy) m_valid = 1'b0;
    @(posedge clk_i);
    #1;
    check("valid_o", 32'(valid_o), 32'(m_valid));
    if (m_valid) check_bundle(m_b);
  endtask

  function automatic vec_t mkv(input logic [31:0] ins, input logic [31:0] pc,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input op_alu_e op, input logic [31:0] in1,
                               input logic [31:0] in2, input logic [4:0] rd,
                               input logic we, input logic ill);
    vec_t r;
    r.instr = ins; r.pc = pc; r.d1 = d1; r.d2 = d2;
    r.exp.op = op; r.exp.in1 = in1; r.exp.in2 = in2; r.exp.pc = pc;
    r.exp.rd = rd; r.exp.we = we; r.exp.ill = ill;
    return r;
  endfunction

  function automatic logic [31:0] r_enc(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] i_enc(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] s_enc(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] b_enc(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] opc);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
  endfunction

  function automatic logic [31:0] j_enc(input logic [20:0] imm, input logic [4:0] rd,
      input logic [6:0] opc);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction

  function automatic logic [31:0] sx12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  // Build a random instruction of a chosen kind and the bundle it must produce
  task automatic gen(input int kind, input logic [31:0] pc, input logic [31:0] d1,
                     input logic [31:0] d2, output logic [31:0] ins, output bnd_t e);
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] i12;
    logic [19:0] u20;
    logic [20:0] j21;
    logic [12:0] b13;
    logic [2:0]  f3;
    int          sub;
    rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    i12 = 12'($urandom); u20 = 20'($urandom);
    j21 = {20'($urandom), 1'b0};
    b13 = {12'($urandom), 1'b0};
    e.op = ALU_NOP; e.in1 = 32'h0; e.in2 = 32'h0; e.pc = pc; e.ill = 1'b0;
    ins = 32'h0;
    case (kind)
      0:  begin ins = r_enc(7'h00, rs2, rs1, 3'd0, rd, 7'h33); e.op = ALU_ADD; e.in1 = d1; e.in2 = d2; end
      1:  begin ins = r_enc(7'h20, rs2, rs1, 3'd0, rd, 7'h33); e.op = ALU_SUB; e.in1 = d1; e.in2 = d2; end
      2:  begin ins = r_enc(7'h00, rs2, rs1, 3'd7, rd, 7'h33); e.op = ALU_AND; e.in1 = d1; e.in2 = d2; end
      3:  begin ins = r_enc(7'h00, rs2, rs1, 3'd6, rd, 7'h33); e.op = ALU_OR;  e.in1 = d1; e.in2 = d2; end
      4:  begin ins = r_enc(7'h00, rs2, rs1, 3'd4, rd, 7'h33); e.op = ALU_XOR; e.in1 = d1; e.in2 = d2; end
      5:  begin ins = r_enc(7'h00, rs2, rs1, 3'd2, rd, 7'h33); e.op = ALU_SLT; e.in1 = d1; e.in2 = d2; end
      6:  begin ins = i_enc(i12, rs1, 3'd0, rd, 7'h13); e.op = ALU_ADD; e.in1 = d1; e.in2 = sx12(i12); end
      7:  begin ins = i_enc(i12, rs1, 3'd7, rd, 7'h13); e.op = ALU_AND; e.in1 = d1; e.in2 = sx12(i12); end
      8:  begin ins = i_enc(i12, rs1, 3'd6, rd, 7'h13); e.op = ALU_OR;  e.in1 = d1; e.in2 = sx12(i12); end
      9:  begin ins = i_enc(i12, rs1, 3'd4, rd, 7'h13); e.op = ALU_XOR; e.in1 = d1; e.in2 = sx12(i12); end
      10: begin ins = i_enc(i12, rs1, 3'd2, rd, 7'h13); e.op = ALU_SLT; e.in1 = d1; e.in2 = sx12(i12); end
      11: begin ins = {u20, rd, 7'h37}; e.op = ALU_ADD; e.in2 = {u20, 12'h000}; end
      12: begin ins = {u20, rd, 7'h17}; e.op = ALU_ADD; e.in1 = pc; e.in2 = {u20, 12'h000}; end
      13: begin ins = j_enc(j21, rd, 7'h6F); e.op = ALU_ADD; e.in1 = pc; e.in2 = {{11{j21[20]}}, j21}; end
      14: begin ins = i_enc(i12, rs1, 3'd0, rd, 7'h67); e.op = ALU_JMPR; e.in1 = d1; e.in2 = sx12(i12); end
      15: begin
        sub = $urandom_range(0, 4);
        f3  = (sub < 3) ? 3'(sub) : 3'(sub + 1);
        ins = i_enc(i12, rs1, f3, rd, 7'h03); e.op = ALU_ADD; e.in1 = d1; e.in2 = sx12(i12);
      end
      16: begin
        f3  = 3'($urandom_range(0, 2));
        ins = s_enc(i12, rs2, rs1, f3, 7'h23); e.op = ALU_ADD; e.in1 = d1; e.in2 = sx12(i12);
      end
      17: begin ins = b_enc(b13, rs2, rs1, 3'd0, 7'h63); e.op = ALU_SUB; e.in1 = d1; e.in2 = d2; end
      18: begin ins = b_enc(b13, rs2, rs1, 3'd1, 7'h63); e.op = ALU_SUB; e.in1 = d1; e.in2 = d2; end
      default: begin
        sub = $urandom_range(0, 6);
        case (sub)
          0: ins = r_enc(7'h00, rs2, rs1, 3'd1, rd, 7'h33);
          1: ins = r_enc(7'h20, rs2, rs1, 3'd5, rd, 7'h33);
          2: ins = r_enc(7'h00, rs2, rs1, 3'd3, rd, 7'h33);
          3: ins = i_enc(i12, rs1, 3'd3, rd, 7'h13);
          4: ins = b_enc(b13, rs2, rs1, 3'd4, 7'h63);
          5: ins = r_enc(7'h20, rs2, rs1, 3'd7, rd, 7'h33);
          default: ins = 32'h0000_0000;
        endcase
        e.ill = 1'b1;
      end
    endcase
    e.rd = ins[11:7];
    e.we = !e.ill && !(kind inside {16, 17, 18}) && (e.rd != 5'd0);
  endtask

  initial begin
    logic [31:0] ins, pc, d1, d2;
    bnd_t        dec;
    reset_b = '{in1: 32'h0, in2: 32'h0, pc: 32'h0, op: ALU_NOP, rd: 5'd0, we: 1'b0, ill: 1'b0};
    m_valid = 1'b0;
    m_b     = reset_b;

    vecs[0]  = mkv(32'hFFB10093, 32'h100, 32'h10, 32'h55, ALU_ADD, 32'h10, 32'hFFFFFFFB, 5'd1, 1'b1, 1'b0);
    vecs[1]  = mkv(32'h402081B3, 32'h104, 32'h7, 32'h3, ALU_SUB, 32'h7, 32'h3, 5'd3, 1'b1, 1'b0);
    vecs[2]  = mkv(32'h006280E7, 32'h108, 32'h1000, 32'h0, ALU_JMPR, 32'h1000, 32'h6, 5'd1, 1'b1, 1'b0);
    vecs[3]  = mkv(32'h123452B7, 32'h10C, 32'hDEAD, 32'hBEEF, ALU_ADD, 32'h0, 32'h12345000, 5'd5, 1'b1, 1'b0);
    vecs[4]  = mkv(32'h00000000, 32'h110, 32'h1, 32'h2, ALU_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    vecs[5]  = mkv(32'h00001397, 32'h200, 32'h9, 32'h9, ALU_ADD, 32'h200, 32'h1000, 5'd7, 1'b1, 1'b0);
    vecs[6]  = mkv(32'hFFDFF0EF, 32'h104, 32'h5, 32'h6, ALU_ADD, 32'h104, 32'hFFFFFFFC, 5'd1, 1'b1, 1'b0);
    vecs[7]  = mkv(32'hFE512E23, 32'h300, 32'h2000, 32'h77, ALU_ADD, 32'h2000, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b0);
    vecs[8]  = mkv(32'h00208463, 32'h304, 32'h5, 32'h9, ALU_SUB, 32'h5, 32'h9, 5'd8, 1'b0, 1'b0);
    vecs[9]  = mkv(32'h0020E033, 32'h308, 32'hF0, 32'h0F, ALU_OR, 32'hF0, 32'h0F, 5'd0, 1'b0, 1'b0);
    vecs[10] = mkv(32'h00309093, 32'h30C, 32'h11, 32'h22, ALU_NOP, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1);
    vecs[11] = mkv(32'h003130B3, 32'h310, 32'h33, 32'h44, ALU_NOP, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1);
    vecs[12] = mkv(32'h7FF24213, 32'h314, 32'hFFFF0000, 32'h0, ALU_XOR, 32'hFFFF0000, 32'h7FF, 5'd4, 1'b1, 1'b0);
    vecs[13] = mkv(32'hFFF02313, 32'h318, 32'h0, 32'h0, ALU_SLT, 32'h0, 32'hFFFFFFFF, 5'd6, 1'b1, 1'b0);
    vecs[14] = mkv(32'h0041F133, 32'h31C, 32'hFF00FF00, 32'h0FF00FF0, ALU_AND, 32'hFF00FF00, 32'h0FF00FF0, 5'd2, 1'b1, 1'b0);

    // Reset state
    rst_ni = 1'b0; valid_i = 1'b0; instr_i = 32'h0; pc_i = 32'h0;
    rs1_data_i = 32'h0; rs2_data_i = 32'h0; flush_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset valid_o", 32'(valid_o), 32'h0);
    check("reset ready_o", 32'(ready_o), 32'h1);
    check_bundle(reset_b);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Directed decode vectors, back to back
    for (int i = 0; i < 15; i++)
      step(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].d1, vecs[i].d2, 1'b0, 1'b1, vecs[i].exp);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, reset_b);

    // Back-pressure: hold A for three cycles while B waits, then B enters
    step(1'b1, vecs[0].instr, vecs[0].pc, vecs[0].d1, vecs[0].d2, 1'b0, 1'b1, vecs[0].exp);
    repeat (3)
      step(1'b1, vecs[1].instr, vecs[1].pc, vecs[1].d1, vecs[1].d2, 1'b0, 1'b0, vecs[1].exp);
    step(1'b1, vecs[1].instr, vecs[1].pc, vecs[1].d1, vecs[1].d2, 1'b0, 1'b1, vecs[1].exp);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, reset_b);

    // Flush with an incoming instruction, empty and full register
    step(1'b1, vecs[3].instr, vecs[3].pc, vecs[3].d1, vecs[3].d2, 1'b1, 1'b1, vecs[3].exp);
    step(1'b1, vecs[2].instr, vecs[2].pc, vecs[2].d1, vecs[2].d2, 1'b0, 1'b1, vecs[2].exp);
    step(1'b1, vecs[5].instr, vecs[5].pc, vecs[5].d1, vecs[5].d2, 1'b1, 1'b0, vecs[5].exp);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, reset_b);

    // Reset asserted in the middle of a stall
    step(1'b1, vecs[12].instr, vecs[12].pc, vecs[12].d1, vecs[12].d2, 1'b0, 1'b1, vecs[12].exp);
    step(1'b1, vecs[13].instr, vecs[13].pc, vecs[13].d1, vecs[13].d2, 1'b0, 1'b0, vecs[13].exp);
    #2;
    rst_ni = 1'b0;
    #1;
    check("midreset valid_o", 32'(valid_o), 32'h0);
    check_bundle(reset_b);
    m_valid = 1'b0;
    m_b     = reset_b;
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("postreset valid_o", 32'(valid_o), 32'h0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      d1 = $urandom;
      d2 = $urandom;
      gen($urandom_range(0, 19), pc, d1, d2, ins, dec);
      step($urandom_range(0, 9) < 7, ins, pc, d1, d2,
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, dec);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
